// File: rtl/btb_update_ctrl_if.sv
// Bundle between the retire bus, the BTB write port and the update scheduler.
// master: commit/BTB side that drives retire updates and flush requests.
// slave:  the btb_update_ctrl scheduler.
interface btb_update_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int BTB_WIDTH   = $clog2(BTB_ENTRIES),
    parameter int QDEPTH      = 8
);
    localparam int TAG_WIDTH = ADDR_WIDTH - BTB_WIDTH - 2;
    localparam int OCC_WIDTH = $clog2(QDEPTH + 1);

    logic                  ret0_valid;
    logic [ADDR_WIDTH-1:0] ret0_pc;
    logic [ADDR_WIDTH-1:0] ret0_target;
    logic                  ret0_taken;
    logic                  ret1_valid;
    logic [ADDR_WIDTH-1:0] ret1_pc;
    logic [ADDR_WIDTH-1:0] ret1_target;
    logic                  ret1_taken;
    logic                  ret_ready;

    logic                  flush_req;
    logic                  flush_busy;
    logic                  flush_done;

    logic                  wr_valid;
    logic                  wr_clear;
    logic [BTB_WIDTH-1:0]  wr_index;
    logic [TAG_WIDTH-1:0]  wr_tag;
    logic [ADDR_WIDTH-1:0] wr_target;
    logic                  wr_taken;

    logic [OCC_WIDTH-1:0]  occupancy;

    modport master (
        output ret0_valid, ret0_pc, ret0_target, ret0_taken,
        output ret1_valid, ret1_pc, ret1_target, ret1_taken,
        output flush_req,
        input  ret_ready, flush_busy, flush_done,
        input  wr_valid, wr_clear, wr_index, wr_tag, wr_target, wr_taken,
        input  occupancy
    );

    modport slave (
        input  ret0_valid, ret0_pc, ret0_target, ret0_taken,
        input  ret1_valid, ret1_pc, ret1_target, ret1_taken,
        input  flush_req,
        output ret_ready, flush_busy, flush_done,
        output wr_valid, wr_clear, wr_index, wr_tag, wr_target, wr_taken,
        output occupancy
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: buffers up to two retired-branch updates per cycle
// in a FIFO, drains one per cycle into the BTB, and walks every index to clear
// the table on a flush request.
// Optional feature macro: BTB_UPD_COALESCE_EN (merge same-index updates).
module btb_update_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int BTB_WIDTH   = $clog2(BTB_ENTRIES),
    parameter int QDEPTH      = 8
) (
    input logic             clk,
    input logic             rst,
    btb_update_ctrl_if.slave bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - BTB_WIDTH - 2;
    localparam int OCC_WIDTH = $clog2(QDEPTH + 1);
    localparam int PTR_WIDTH = $clog2(QDEPTH);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    typedef struct packed {
        logic [BTB_WIDTH-1:0]  index;
        logic [TAG_WIDTH-1:0]  tag;
        logic [ADDR_WIDTH-1:0] target;
        logic                  taken;
    } entry_t;

    state_e               state_q, state_d;
    logic [BTB_WIDTH-1:0] walk_q, walk_d;
    logic                 flush_done_q, flush_done_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    entry_t               mem_q [QDEPTH];
    entry_t               mem_d [QDEPTH];

    entry_t               ent0, ent1, head;
    logic                 ret_ready;
    logic                 acc0, acc1, deq;
    logic [1:0]           enq_cnt;
    logic [PTR_WIDTH-1:0] ptr;
`ifdef BTB_UPD_COALESCE_EN
    logic [PTR_WIDTH-1:0] tail_ptr;
    entry_t               single;
`endif

    assign ent0 = '{index:  bus.ret0_pc[BTB_WIDTH+1:2],
                    tag:    bus.ret0_pc[ADDR_WIDTH-1:BTB_WIDTH+2],
                    target: bus.ret0_target,
                    taken:  bus.ret0_taken};
    assign ent1 = '{index:  bus.ret1_pc[BTB_WIDTH+1:2],
                    tag:    bus.ret1_pc[ADDR_WIDTH-1:BTB_WIDTH+2],
                    target: bus.ret1_target,
                    taken:  bus.ret1_taken};
    assign head = mem_q[rd_ptr_q];

    // Commit may present updates only in RUN with room for a full pair.
    assign ret_ready = (state_q == ST_RUN) &&
                       (occ_q <= OCC_WIDTH'(QDEPTH - 2)) && !bus.flush_req;

    assign bus.ret_ready  = ret_ready;
    assign bus.flush_busy = (state_q == ST_FLUSH);
    assign bus.flush_done = flush_done_q;
    assign bus.occupancy  = occ_q;

    // Next-state, FIFO bookkeeping and write-port drive.
    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so later statements see earlier results and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        walk_d       = walk_q;
        flush_done_d = 1'b0;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        occ_d        = occ_q;
        mem_d        = mem_q;
        acc0         = ret_ready && bus.ret0_valid;
        acc1         = ret_ready && bus.ret1_valid;
        deq          = 1'b0;
        enq_cnt      = 2'd0;
        ptr          = wr_ptr_q;
        bus.wr_valid  = 1'b0;
        bus.wr_clear  = 1'b0;
        bus.wr_index  = '0;
        bus.wr_tag    = '0;
        bus.wr_target = '0;
        bus.wr_taken  = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
        tail_ptr = wr_ptr_q - PTR_WIDTH'(1);
        single   = ent1;
`endif

        case (state_q)
            ST_RUN: begin
                deq = (occ_q != '0);
                if (deq) begin
                    bus.wr_valid  = 1'b1;
                    bus.wr_index  = head.index;
                    bus.wr_tag    = head.tag;
                    bus.wr_target = head.target;
                    bus.wr_taken  = head.taken;
                end
`ifdef BTB_UPD_COALESCE_EN
                // A same-index pair collapses to the younger slot.
                if (acc0 && acc1 && (ent0.index == ent1.index)) begin
                    acc0 = 1'b0;
                end
                // A lone update to the tail's index overwrites it in place;
                // with two or more held, the tail cannot be the popping head.
                single = acc0 ? ent0 : ent1;
                if ((acc0 ^ acc1) && (occ_q >= OCC_WIDTH'(2)) &&
                    (mem_q[tail_ptr].index == single.index)) begin
                    mem_d[tail_ptr] = single;
                    acc0 = 1'b0;
                    acc1 = 1'b0;
                end
`endif
                if (acc0) begin
                    mem_d[ptr] = ent0;
                    ptr        = ptr + PTR_WIDTH'(1);
                    enq_cnt    = enq_cnt + 2'd1;
                end
                if (acc1) begin
                    mem_d[ptr] = ent1;
                    ptr        = ptr + PTR_WIDTH'(1);
                    enq_cnt    = enq_cnt + 2'd1;
                end
                wr_ptr_d = ptr;
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(deq);
                occ_d    = occ_q + OCC_WIDTH'(enq_cnt) - OCC_WIDTH'(deq);

                // Flush discards the queue; this cycle's pop still goes out.
                if (bus.flush_req) begin
                    state_d  = ST_FLUSH;
                    walk_d   = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    occ_d    = '0;
                end
            end

            ST_FLUSH: begin
                bus.wr_valid = 1'b1;
                bus.wr_clear = 1'b1;
                bus.wr_index = walk_q;
                if (bus.flush_req) begin
                    walk_d = '0;
                end else if (walk_q == BTB_WIDTH'(BTB_ENTRIES - 1)) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end else begin
                    walk_d = walk_q + BTB_WIDTH'(1);
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            walk_q       <= '0;
            flush_done_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            state_q      <= state_d;
            walk_q       <= walk_d;
            flush_done_q <= flush_done_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
        end
    end

    // FIFO storage.
    // NOTE: entry storage has no reset; occupancy gates every read, so stale
    // contents are never observed and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl (default parameters).
`timescale 1ns/1ps
module tb_btb_update_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    btb_update_ctrl_if bus_if ();

    btb_update_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.ret0_valid  = 1'b0;
        bus_if.ret0_pc     = '0;
        bus_if.ret0_target = '0;
        bus_if.ret0_taken  = 1'b0;
        bus_if.ret1_valid  = 1'b0;
        bus_if.ret1_pc     = '0;
        bus_if.ret1_target = '0;
        bus_if.ret1_taken  = 1'b0;
        bus_if.flush_req   = 1'b0;
    endtask

    task automatic drive(input logic v0, input logic [31:0] pc0, input logic [31:0] t0, input logic k0,
                         input logic v1, input logic [31:0] pc1, input logic [31:0] t1, input logic k1);
        bus_if.ret0_valid  = v0;
        bus_if.ret0_pc     = pc0;
        bus_if.ret0_target = t0;
        bus_if.ret0_taken  = k0;
        bus_if.ret1_valid  = v1;
        bus_if.ret1_pc     = pc1;
        bus_if.ret1_target = t1;
        bus_if.ret1_taken  = k1;
    endtask

    initial begin
        int n_wr;
        logic [31:0] pc;
        n_cmp = 0;
        n_err = 0;
        idle();

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_occ", 64'(bus_if.occupancy), 64'd0);
        check("rst_ready", 64'(bus_if.ret_ready), 64'd1);
        check("rst_busy", 64'(bus_if.flush_busy), 64'd0);
        check("rst_done", 64'(bus_if.flush_done), 64'd0);
        check("rst_wr_valid", 64'(bus_if.wr_valid), 64'd0);
        check("rst_wr_clear", 64'(bus_if.wr_clear), 64'd0);
        check("rst_wr_index", 64'(bus_if.wr_index), 64'd0);

        // Single slot-0 update: written the following cycle.
        drive(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        check("t1_no_same_cycle_wr", 64'(bus_if.wr_valid), 64'd0);
        tick();
        idle();
        #1;
        check("t1_wr_valid", 64'(bus_if.wr_valid), 64'd1);
        check("t1_wr_clear", 64'(bus_if.wr_clear), 64'd0);
        check("t1_wr_index", 64'(bus_if.wr_index), 64'd0);
        check("t1_wr_tag", 64'(bus_if.wr_tag), 64'h4);
        check("t1_wr_target", 64'(bus_if.wr_target), 64'h200);
        check("t1_wr_taken", 64'(bus_if.wr_taken), 64'd1);
        check("t1_occ", 64'(bus_if.occupancy), 64'd1);
        tick();
        #1;
        check("t1_occ_back", 64'(bus_if.occupancy), 64'd0);
        check("t1_wr_idle", 64'(bus_if.wr_valid), 64'd0);

        // Six back-to-back pairs; update i has pc 0x1000+4i (index i, tag 0x40).
        n_wr = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 6)
                drive(1'b1, 32'h1000 + 32'(8 * cyc),     32'h2000_0000 + 32'(8 * cyc),     1'b0,
                      1'b1, 32'h1000 + 32'(8 * cyc + 4), 32'h2000_0000 + 32'(8 * cyc + 4), 1'b1);
            else
                idle();
            #1;
            if (cyc == 0) check("t2_occ_c0", 64'(bus_if.occupancy), 64'd0);
            if (cyc >= 1 && cyc < 6) check("t2_occ_ramp", 64'(bus_if.occupancy), 64'(cyc + 1));
            if (cyc < 6) check("t2_ready_open", 64'(bus_if.ret_ready), 64'd1);
            if (cyc == 6) begin
                check("t2_occ_peak", 64'(bus_if.occupancy), 64'd7);
                check("t2_ready_drop", 64'(bus_if.ret_ready), 64'd0);
            end
            check("t2_occ_bound", 64'(bus_if.occupancy <= 4'd8), 64'd1);
            if (bus_if.wr_valid) begin
                check("t2_order_index", 64'(bus_if.wr_index), 64'(n_wr));
                check("t2_order_tag", 64'(bus_if.wr_tag), 64'h40);
                check("t2_order_target", 64'(bus_if.wr_target), 64'h2000_0000 + 64'(4 * n_wr));
                check("t2_order_taken", 64'(bus_if.wr_taken), 64'(n_wr % 2));
                n_wr++;
            end
            tick();
        end
        check("t2_write_count", 64'(n_wr), 64'd12);
        check("t2_occ_drained", 64'(bus_if.occupancy), 64'd0);

        // Lone slot-1 update at pc 0x3C -> index 15.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C, 32'h500, 1'b0);
        tick();
        idle();
        #1;
        check("t3_wr_valid", 64'(bus_if.wr_valid), 64'd1);
        check("t3_wr_index", 64'(bus_if.wr_index), 64'd15);
        check("t3_wr_tag", 64'(bus_if.wr_tag), 64'd0);
        check("t3_wr_target", 64'(bus_if.wr_target), 64'h500);
        check("t3_occ", 64'(bus_if.occupancy), 64'd1);
        tick();
        #1;
        check("t3_single_write", 64'(bus_if.wr_valid), 64'd0);

        // Queue 5 updates, then flush: queue discarded, full walk, done pulse.
        for (int k = 0; k < 4; k++) begin
            pc = 32'h8000 + 32'(16 * k);
            drive(1'b1, pc, 32'h9000, 1'b1, 1'b1, pc + 32'h8, 32'h9004, 1'b0);
            tick();
        end
        idle();
        #1;
        check("t4_occ_queued", 64'(bus_if.occupancy), 64'd5);
        bus_if.flush_req = 1'b1;
        drive(1'b1, 32'h4000, 32'h4100, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        check("t4_ready_on_req", 64'(bus_if.ret_ready), 64'd0);
        check("t4_deq_completes", 64'(bus_if.wr_valid), 64'd1);
        check("t4_deq_not_clear", 64'(bus_if.wr_clear), 64'd0);
        tick();
        idle();
        for (int j = 0; j < 16; j++) begin
            #1;
            check("t4_walk_busy", 64'(bus_if.flush_busy), 64'd1);
            check("t4_walk_clear", 64'(bus_if.wr_valid & bus_if.wr_clear), 64'd1);
            check("t4_walk_index", 64'(bus_if.wr_index), 64'(j));
            check("t4_walk_ready", 64'(bus_if.ret_ready), 64'd0);
            check("t4_walk_occ", 64'(bus_if.occupancy), 64'd0);
            check("t4_walk_no_done", 64'(bus_if.flush_done), 64'd0);
            tick();
        end
        #1;
        check("t4_done_pulse", 64'(bus_if.flush_done), 64'd1);
        check("t4_busy_clear", 64'(bus_if.flush_busy), 64'd0);
        check("t4_ready_back", 64'(bus_if.ret_ready), 64'd1);
        check("t4_queue_dropped", 64'(bus_if.wr_valid), 64'd0);
        tick();
        #1;
        check("t4_done_one_cycle", 64'(bus_if.flush_done), 64'd0);
        check("t4_still_idle", 64'(bus_if.wr_valid), 64'd0);

        // Flush restarted at walk index 9.
        bus_if.flush_req = 1'b1;
        tick();
        bus_if.flush_req = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 9) bus_if.flush_req = 1'b1;
            #1;
            check("t5_pre_index", 64'(bus_if.wr_index), 64'(j));
            tick();
        end
        bus_if.flush_req = 1'b0;
        for (int j = 0; j < 16; j++) begin
            #1;
            check("t5_restart_index", 64'(bus_if.wr_index), 64'(j));
            check("t5_restart_clear", 64'(bus_if.wr_clear), 64'd1);
            tick();
        end
        #1;
        check("t5_done_pulse", 64'(bus_if.flush_done), 64'd1);
        check("t5_busy_clear", 64'(bus_if.flush_busy), 64'd0);
        tick();

        // Same-index pair: pc 0x104 (tag 4) and 0x144 (tag 5), both index 1.
        drive(1'b1, 32'h104, 32'hA00, 1'b0, 1'b1, 32'h144, 32'hB00, 1'b1);
        tick();
        idle();
        #1;
`ifdef BTB_UPD_COALESCE_EN
        check("t6_occ", 64'(bus_if.occupancy), 64'd1);
        check("t6_wr_index", 64'(bus_if.wr_index), 64'd1);
        check("t6_wr_tag", 64'(bus_if.wr_tag), 64'd5);
        check("t6_wr_target", 64'(bus_if.wr_target), 64'hB00);
        check("t6_wr_taken", 64'(bus_if.wr_taken), 64'd1);
        tick();
        #1;
        check("t6_single_write", 64'(bus_if.wr_valid), 64'd0);
`else
        check("t6_occ", 64'(bus_if.occupancy), 64'd2);
        check("t6_first_index", 64'(bus_if.wr_index), 64'd1);
        check("t6_first_tag", 64'(bus_if.wr_tag), 64'd4);
        check("t6_first_target", 64'(bus_if.wr_target), 64'hA00);
        check("t6_first_taken", 64'(bus_if.wr_taken), 64'd0);
        tick();
        #1;
        check("t6_second_valid", 64'(bus_if.wr_valid), 64'd1);
        check("t6_second_tag", 64'(bus_if.wr_tag), 64'd5);
        check("t6_second_target", 64'(bus_if.wr_target), 64'hB00);
        check("t6_second_taken", 64'(bus_if.wr_taken), 64'd1);
        tick();
        #1;
        check("t6_two_writes_only", 64'(bus_if.wr_valid), 64'd0);
`endif

        // Asynchronous reset mid-drain drops the queue immediately.
        drive(1'b1, 32'h2000, 32'h2100, 1'b1, 1'b1, 32'h2010, 32'h2200, 1'b0);
        tick();
        idle();
        #1;
        check("t7_occ_before", 64'(bus_if.occupancy), 64'd2);
        rst = 1'b1;
        #1;
        check("t7_async_occ", 64'(bus_if.occupancy), 64'd0);
        check("t7_async_wr", 64'(bus_if.wr_valid), 64'd0);
        #1 rst = 1'b0;
        tick();
        #1;
        check("t7_after_occ", 64'(bus_if.occupancy), 64'd0);
        check("t7_after_wr", 64'(bus_if.wr_valid), 64'd0);
        check("t7_after_ready", 64'(bus_if.ret_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
